// File: rtl/seq_pattern_tx.sv
// Serial stimulus transmitter for the two-in-a-row sequence detector, with an
// embedded reference model of that detector producing the expected z.
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             w,
  output logic             w_valid,
  output logic             done,
  output logic [2:0]       exp_state,
  output logic             exp_z
);

  localparam int unsigned SW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [LEN_W-1:0] cnt;

  logic             len_ok;
  logic [WIDTH-1:0] aligned;
  logic [SW-1:0]    ref_nxt;

  // Left-justify the requested bits so the first one sits at the MSB.
  assign len_ok  = (len != '0) && (len <= LEN_W'(WIDTH));
  assign aligned = data << (LEN_W'(WIDTH) - len);

  // Reference detector next state for the bit currently on the line.
  always_comb begin
    ref_nxt = SW'(0);
    unique case (exp_state)
      SW'(0):  ref_nxt = w ? SW'(3) : SW'(1);
      SW'(1):  ref_nxt = w ? SW'(3) : SW'(2);
      SW'(2):  ref_nxt = w ? SW'(3) : SW'(2);
      SW'(3):  ref_nxt = w ? SW'(4) : SW'(1);
      SW'(4):  ref_nxt = w ? SW'(4) : SW'(1);
      default: ref_nxt = SW'(0);
    endcase
  end

  function automatic logic z_of(input logic [SW-1:0] s);
    return (s == SW'(2)) || (s == SW'(4));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      w         <= 1'b0;
      w_valid   <= 1'b0;
      done      <= 1'b0;
      exp_state <= '0;
      exp_z     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && len_ok) begin
            state     <= SHIFT;
            w         <= aligned[WIDTH-1];
            shreg     <= aligned << 1;
            cnt       <= len;
            w_valid   <= 1'b1;
            busy      <= 1'b1;
            exp_state <= '0;
            exp_z     <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_valid) begin
            exp_state <= ref_nxt;
            exp_z     <= z_of(ref_nxt);
          end
          // cnt counts bits still on or awaiting the line, including the current one.
          if (cnt == LEN_W'(1)) begin
            state   <= DONE;
            w       <= 1'b0;
            w_valid <= 1'b0;
            done    <= 1'b1;
            shreg   <= '0;
            cnt     <= '0;
          end else begin
            w     <= shreg[WIDTH-1];
            shreg <= shreg << 1;
            cnt   <= cnt - LEN_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          w       <= 1'b0;
          w_valid <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized bench for seq_pattern_tx; the expected detector state is derived
// from the last two bits consumed since the most recent clear.
module tb_seq_pattern_tx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] data;
  logic [LEN_W-1:0] len;
  logic             busy, w, w_valid, done, exp_z;
  logic [2:0]       exp_state;

  int n_chk = 0;
  int n_err = 0;

  // Model: bits consumed since clear, and the two most recent of them.
  int nb = 0;
  bit last_b = 1'b0;
  bit prev_b = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .len(len),
    .busy(busy), .w(w), .w_valid(w_valid), .done(done),
    .exp_state(exp_state), .exp_z(exp_z)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Detector state: no bits consumed -> 0; last bit 0 -> 1 (or 2 if pair); last bit 1 -> 3 (or 4 if pair).
  function automatic int ref_state();
    if (nb == 0) return 0;
    if (nb >= 2 && last_b == prev_b) return last_b ? 4 : 2;
    return last_b ? 3 : 1;
  endfunction

  function automatic bit ref_z();
    return (nb >= 2) && (last_b == prev_b);
  endfunction

  task automatic push_bit(input bit b);
    prev_b = last_b;
    last_b = b;
    nb++;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".busy"}, 32'(busy), 0);
    check_eq({tag, ".w"}, 32'(w), 0);
    check_eq({tag, ".w_valid"}, 32'(w_valid), 0);
    check_eq({tag, ".done"}, 32'(done), 0);
    check_eq({tag, ".exp_state"}, 32'(exp_state), 32'(ref_state()));
    check_eq({tag, ".exp_z"}, 32'(exp_z), 32'(ref_z()));
  endtask

  task automatic drive_noise(input bit noise);
    start = noise ? 1'($urandom) : 1'b0;
    if (start) begin
      data = 8'($urandom);
      len  = LEN_W'($urandom);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE with start low.
  task automatic send(input logic [7:0] d, input int l, input bit noise, input int abort_at);
    start = 1'b1;
    data  = d;
    len   = LEN_W'(l);
    @(negedge clk);
    nb = 0;
    for (int k = 0; k < l; k++) begin
      check_eq("bit.w", 32'(w), 32'(d[l-1-k]));
      check_eq("bit.w_valid", 32'(w_valid), 1);
      check_eq("bit.busy", 32'(busy), 1);
      check_eq("bit.done", 32'(done), 0);
      check_eq("bit.exp_state", 32'(exp_state), 32'(ref_state()));
      check_eq("bit.exp_z", 32'(exp_z), 32'(ref_z()));
      if (k == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        nb = 0;
        check_idle("abort");
        return;
      end
      push_bit(d[l-1-k]);
      drive_noise(noise);
      @(negedge clk);
    end
    check_eq("done.done", 32'(done), 1);
    check_eq("done.busy", 32'(busy), 1);
    check_eq("done.w", 32'(w), 0);
    check_eq("done.w_valid", 32'(w_valid), 0);
    check_eq("done.exp_state", 32'(exp_state), 32'(ref_state()));
    check_eq("done.exp_z", 32'(exp_z), 32'(ref_z()));
    drive_noise(noise);
    @(negedge clk);
    start = 1'b0;
    check_idle("post");
  endtask

  task automatic send_illegal(input int l);
    start = 1'b1;
    data  = 8'($urandom);
    len   = LEN_W'(l);
    @(negedge clk);
    start = 1'b0;
    check_idle("illegal");
    @(negedge clk);
    check_idle("illegal2");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    data  = '0;
    len   = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset_rel");

    send(8'b0011_0110, 8, 1'b0, -1);
    send(8'hFD, 3, 1'b0, -1);
    check_eq("t2.exp_state", 32'(exp_state), 3);
    send_illegal(0);
    send_illegal(9);
    check_eq("t3.exp_state", 32'(exp_state), 3);
    send(8'b0011_0110, 8, 1'b1, -1);
    send(8'b0011_0110, 8, 1'b0, 3);
    send(8'hFF, 8, 1'b0, -1);
    send(8'b00, 2, 1'b0, -1);
    send(8'b11, 2, 1'b0, -1);
    check_eq("t6.exp_state", 32'(exp_state), 4);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        send_illegal(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 15)));
      end else begin
        int l;
        int ab;
        l  = int'($urandom_range(1, 8));
        ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, l - 1)) : -1;
        send(8'($urandom), l, 1'($urandom), ab);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
